// File: rtl/pn_marking_reader.sv
// Snapshot reader for the Petri-net executor: captures the marking on a step boundary and streams it as a framed byte sequence.
// Optional trailing checksum byte is enabled by defining PN_READER_CKSUM_EN.
module pn_marking_reader #(
  parameter int          NPLACES = 46,
  parameter logic [7:0]  HDR     = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NPLACES*8-1:0] marking,
  input  logic                 fire_done,
  input  logic                 snap_req,
  output logic                 busy,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready
);

  localparam int IW = (NPLACES > 1) ? $clog2(NPLACES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NPLACES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_HDR,
    S_CNT_HI,
    S_CNT_LO,
    S_PLACE
`ifdef PN_READER_CKSUM_EN
    , S_CKSUM
`endif
  } state_t;

  state_t          state, state_next;
  logic [15:0]     step_cnt;
  logic [15:0]     cnt_cap;
  logic [IW-1:0]   idx;
  logic [7:0]      shadow [NPLACES];
  logic            xfer;
  logic            capture;
  logic            last_place;
`ifdef PN_READER_CKSUM_EN
  logic [7:0]      acc;
`endif

  assign xfer       = tx_valid & tx_ready;
  assign capture    = (state == S_ARM) && fire_done;
  assign last_place = (idx == LAST);
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // The step counter runs in every state; the captured count includes the capturing pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt <= 16'h0000;
      cnt_cap  <= 16'h0000;
      idx      <= '0;
    end else begin
      if (fire_done) step_cnt <= step_cnt + 16'd1;
      if (capture) begin
        cnt_cap <= step_cnt + 16'd1;
        idx     <= '0;
      end else if (state == S_PLACE && xfer) begin
        idx <= last_place ? '0 : idx + IW'(1);
      end
    end
  end

  // Shadow copy is deliberately left out of reset; it is always loaded before being read.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int k = 0; k < NPLACES; k++) shadow[k] <= marking[8*k +: 8];
    end
  end

`ifdef PN_READER_CKSUM_EN
  always_ff @(posedge clk) begin
    if (rst)          acc <= 8'h00;
    else if (capture) acc <= 8'h00;
    else if (xfer)    acc <= acc + tx_data;
  end
`endif

  always_comb begin
    state_next = state;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    case (state)
      S_IDLE: if (snap_req) state_next = S_ARM;
      S_ARM:  if (fire_done) state_next = S_HDR;
      S_HDR: begin
        tx_valid = 1'b1;
        tx_data  = HDR;
        if (tx_ready) state_next = S_CNT_HI;
      end
      S_CNT_HI: begin
        tx_valid = 1'b1;
        tx_data  = cnt_cap[15:8];
        if (tx_ready) state_next = S_CNT_LO;
      end
      S_CNT_LO: begin
        tx_valid = 1'b1;
        tx_data  = cnt_cap[7:0];
        if (tx_ready) state_next = S_PLACE;
      end
      S_PLACE: begin
        tx_valid = 1'b1;
        tx_data  = shadow[idx];
`ifdef PN_READER_CKSUM_EN
        if (tx_ready && last_place) state_next = S_CKSUM;
`else
        if (tx_ready && last_place) state_next = S_IDLE;
`endif
      end
`ifdef PN_READER_CKSUM_EN
      S_CKSUM: begin
        tx_valid = 1'b1;
        tx_data  = 8'h00 - acc;
        if (tx_ready) state_next = S_IDLE;
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pn_marking_reader.sv
// Scoreboard bench for pn_marking_reader: a frame-level model pushes expected bytes, a monitor pops them on every transfer.
// Honours PN_READER_CKSUM_EN the same way the design does.
module tb_pn_marking_reader;

  localparam int         NPLACES = 46;
  localparam logic [7:0] HDRB    = 8'hA5;
`ifdef PN_READER_CKSUM_EN
  localparam int FLEN = NPLACES + 4;
`else
  localparam int FLEN = NPLACES + 3;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NPLACES*8-1:0] marking = '0;
  logic                 fire_done = 1'b0;
  logic                 snap_req = 1'b0;
  logic                 busy;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready = 1'b1;

  pn_marking_reader #(.NPLACES(NPLACES), .HDR(HDRB)) dut (
    .clk(clk), .rst(rst), .marking(marking), .fire_done(fire_done),
    .snap_req(snap_req), .busy(busy), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] expq[$];
  logic [7:0] rxq[$];
  logic [7:0] base[$];

  typedef enum {M_IDLE, M_ARMED, M_STREAM} mmode_t;
  mmode_t      mmode = M_IDLE;
  int          remaining = 0;
  logic [15:0] mcnt = 16'h0000;
  logic [15:0] ncnt;
  bit          monEn = 1'b0;
  int          rmode = 0;
  int          phase = 0;
  bit          perturb = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Frame as the host sees it: header, count, places, then byte making the total sum zero.
  task automatic pushFrame(input logic [15:0] cnt);
    logic [7:0] frame[$];
    logic [7:0] sum;
    frame.push_back(HDRB);
    frame.push_back(cnt[15:8]);
    frame.push_back(cnt[7:0]);
    for (int k = 0; k < NPLACES; k++) frame.push_back(marking[8*k +: 8]);
    sum = 8'h00;
    foreach (frame[i]) sum = sum + frame[i];
`ifdef PN_READER_CKSUM_EN
    frame.push_back(8'h00 - sum);
`endif
    foreach (frame[i]) expq.push_back(frame[i]);
  endtask

  // Reference model: request/arm/stream behaviour observed at each active edge.
  always @(posedge clk) begin
    if (rst) begin
      mmode = M_IDLE;
      remaining = 0;
      mcnt = 16'h0000;
      expq.delete();
    end else begin
      ncnt = mcnt + {15'd0, fire_done};
      case (mmode)
        M_IDLE:  if (snap_req) mmode = M_ARMED;
        M_ARMED: if (fire_done) begin
          pushFrame(ncnt);
          remaining = FLEN;
          mmode = M_STREAM;
        end
        M_STREAM: if (tx_ready) begin
          remaining--;
          if (remaining == 0) mmode = M_IDLE;
        end
        default: mmode = M_IDLE;
      endcase
      mcnt = ncnt;
    end
  end

  bit         prevHold = 1'b0;
  logic [7:0] prevData = 8'h00;
  logic       prevRst = 1'b0;

  // Monitor: handshake flags vs. model, hold-while-stalled, and byte-by-byte scoreboard.
  always @(negedge clk) begin
    if (monEn) begin
      checkOutput("busy", {31'd0, busy}, {31'd0, mmode != M_IDLE});
      checkOutput("tx_valid", {31'd0, tx_valid}, {31'd0, mmode == M_STREAM});
      if (prevHold && !prevRst) begin
        checkOutput("hold_valid", {31'd0, tx_valid}, 32'd1);
        checkOutput("hold_data", {24'd0, tx_data}, {24'd0, prevData});
      end
      if (tx_valid && tx_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_byte: got %0h, expected no transfer at %0t", tx_data, $time);
        end else begin
          checkOutput("frame_byte", {24'd0, tx_data}, {24'd0, expq.pop_front()});
        end
        rxq.push_back(tx_data);
      end
      prevHold = tx_valid && !tx_ready;
      prevData = tx_data;
      prevRst  = rst;
    end else begin
      prevHold = 1'b0;
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
    phase++;
    case (rmode)
      0: tx_ready = 1'b1;
      1: tx_ready = ((phase % 4) == 0) || ((phase % 4) == 3);
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
    if (perturb) begin
      for (int k = 0; k < NPLACES - 1; k++) marking[8*k +: 8] = 8'($urandom);
      marking[8*(NPLACES-1) +: 8] = 8'h3F;
    end
  endtask

  task automatic applyStimulus(input logic req, input logic fire);
    snap_req  = req;
    fire_done = fire;
    stepCycle();
  endtask

  task automatic waitFrameDone(input int budget, input bit fireRand);
    int n;
    n = 0;
    do begin
      applyStimulus(1'b0, fireRand ? 1'($urandom_range(0, 1)) : 1'b0);
      n++;
    end while (busy && n < budget);
    if (busy) checkOutput("frame_timeout", 32'd1, 32'd0);
  endtask

  task automatic setBaseline();
    marking = '0;
    marking[8*13 +: 8] = 8'h01;
    marking[8*14 +: 8] = 8'h02;
    marking[8*15 +: 8] = 8'h02;
    marking[8*16 +: 8] = 8'h02;
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (3) applyStimulus(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic runFrame();
    rxq.delete();
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    waitFrameDone(400, 1'b0);
  endtask

  initial begin
    int n;
    doReset();
    checkOutput("reset_valid", {31'd0, tx_valid}, 32'd0);
    checkOutput("reset_data", {24'd0, tx_data}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    monEn = 1'b1;

    $display("[TB] baseline frame");
    setBaseline();
    rmode = 0;
    runFrame();
    checkOutput("base_len", rxq.size(), FLEN);
    if (rxq.size() == FLEN) begin
      checkOutput("base_hdr", {24'd0, rxq[0]}, 32'hA5);
      checkOutput("base_cnt_hi", {24'd0, rxq[1]}, 32'h00);
      checkOutput("base_cnt_lo", {24'd0, rxq[2]}, 32'h01);
      checkOutput("base_p13", {24'd0, rxq[16]}, 32'h01);
      checkOutput("base_p16", {24'd0, rxq[19]}, 32'h02);
`ifdef PN_READER_CKSUM_EN
      checkOutput("base_cksum", {24'd0, rxq[FLEN-1]}, 32'h53);
`else
      checkOutput("base_last_p45", {24'd0, rxq[FLEN-1]}, 32'h00);
`endif
    end
    base = rxq;

    $display("[TB] backpressure");
    rmode = 1;
    runFrame();
    checkOutput("bp_len", rxq.size(), FLEN);
    if (rxq.size() == FLEN) begin
      for (int i = 3; i < FLEN - 1; i++) checkOutput("bp_place", {24'd0, rxq[i]}, {24'd0, base[i]});
    end

    $display("[TB] snapshot isolation");
    rmode = 0;
    rxq.delete();
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    perturb = 1'b1;
    applyStimulus(1'b0, 1'b1);
    waitFrameDone(400, 1'b0);
    perturb = 1'b0;
    checkOutput("iso_len", rxq.size(), FLEN);
    if (rxq.size() == FLEN) checkOutput("iso_p45", {24'd0, rxq[3 + NPLACES - 1]}, 32'h00);
    setBaseline();

    $display("[TB] counter wrap and ignored request");
    doReset();
    repeat (65535) applyStimulus(1'b0, 1'b1);
    rxq.delete();
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) applyStimulus(i == 5, 1'b0);
    waitFrameDone(400, 1'b0);
    repeat (20) applyStimulus(1'b0, 1'b0);
    checkOutput("wrap_len", rxq.size(), FLEN);
    if (rxq.size() == FLEN) begin
      checkOutput("wrap_cnt_hi", {24'd0, rxq[1]}, 32'h00);
      checkOutput("wrap_cnt_lo", {24'd0, rxq[2]}, 32'h00);
    end

    $display("[TB] reset mid-frame");
    rxq.delete();
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    n = 0;
    while (rxq.size() < 10 && n < 100) begin
      applyStimulus(1'b0, 1'b0);
      n++;
    end
    if (rxq.size() < 10) checkOutput("rst_wait_timeout", 32'd1, 32'd0);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("rst_valid", {31'd0, tx_valid}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    n = rxq.size();
    repeat (20) applyStimulus(1'b0, 1'b0);
    checkOutput("rst_no_bytes", rxq.size(), n);
    rxq.delete();
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    waitFrameDone(400, 1'b0);
    checkOutput("rst_len", rxq.size(), FLEN);
    if (rxq.size() == FLEN) begin
      checkOutput("rst_cnt_hi", {24'd0, rxq[1]}, 32'h00);
      checkOutput("rst_cnt_lo", {24'd0, rxq[2]}, 32'h01);
    end

    $display("[TB] randomized traffic");
    rmode = 2;
    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < NPLACES; k++) marking[8*k +: 8] = 8'($urandom);
      for (int c = 0; c < 400; c++) begin
        if ($urandom_range(0, 15) == 0) marking[8*$urandom_range(0, NPLACES-1) +: 8] = 8'($urandom);
        applyStimulus(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) == 0));
      end
      waitFrameDone(600, 1'b1);
    end
    rmode = 0;
    repeat (5) applyStimulus(1'b0, 1'b0);
    checkOutput("scoreboard_empty", expq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
